instr_fetch_unit: RTL and testbench

- Fetch side of the multicycle CPU instruction path.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Captures the returned word and drives IDataOut plus a one-cycle IRWre strobe to the instruction register.
- Computes the next PC from the control unit's PCSrc selection when PCWre is asserted.

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle CPU: owns the PC, reads instruction words over req/ack, strobes IR.
// Optional macro FETCH_TIMEOUT_EN bounds the wait for IAck and raises a sticky FetchErr.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ExtImm,
  input  logic [31:0] ReadData1,
  input  logic [25:0] JumpAddr,
  output logic [31:0] IAddr,
  output logic        IReq,
  input  logic        IAck,
  input  logic [31:0] IRData,
  output logic [31:0] IDataOut,
  output logic        IRWre,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        Halted,
  output logic        FetchErr
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DELIVER = 2'd1,
    S_EXEC    = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] idata_q;
  logic [31:0] next_pc_d;
  logic        ireq_q;
  logic        irwre_q;
  logic        halted_q;
  logic        fetch_err_q;
  logic        xfer_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  // A transfer needs our own registered request, so acks seen while idle are ignored.
  assign xfer_s = (state_q == S_FETCH) && ireq_q && IAck;

  // Next-PC selection; all arithmetic wraps silently at 32 bits.
  always_comb begin
    next_pc_d = pc4_q;
    case (PCSrc)
      2'b00:   next_pc_d = pc4_q;
      2'b01:   next_pc_d = pc4_q + (ExtImm << 2);
      2'b10:   next_pc_d = ReadData1 & 32'hFFFF_FFFC;
      2'b11:   next_pc_d = {pc4_q[31:28], JumpAddr, 2'b00};
      default: next_pc_d = pc4_q;
    endcase
  end

  // Fetch state machine with registered handshake and status outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      pc4_q       <= RESET_PC + 32'd4;
      idata_q     <= 32'd0;
      ireq_q      <= 1'b0;
      irwre_q     <= 1'b0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      irwre_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (xfer_s) begin
            idata_q <= IRData;
            ireq_q  <= 1'b0;
            irwre_q <= 1'b1;
            state_q <= S_DELIVER;
`ifdef FETCH_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            fetch_err_q <= 1'b1;
            ireq_q      <= 1'b0;
            halted_q    <= 1'b1;
            state_q     <= S_HALTED;
          end else begin
            ireq_q <= 1'b1;
            tmo_q  <= tmo_q + TMO_W'(1);
          end
`else
          end else begin
            ireq_q <= 1'b1;
          end
`endif
        end
        S_DELIVER: begin
          if (idata_q[31:26] == HALT_OP) begin
            halted_q <= 1'b1;
            state_q  <= S_HALTED;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (PCWre) begin
            pc_q    <= next_pc_d;
            pc4_q   <= next_pc_d + 32'd4;
            ireq_q  <= 1'b1;
            state_q <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end else begin
            ireq_q <= 1'b0;
          end
        end
        S_HALTED: begin
          halted_q <= 1'b1;
          ireq_q   <= 1'b0;
        end
        default: begin
          ireq_q   <= 1'b0;
          halted_q <= 1'b1;
          state_q  <= S_HALTED;
        end
      endcase
    end
  end

  assign IAddr    = pc_q;
  assign IReq     = ireq_q;
  assign IDataOut = idata_q;
  assign IRWre    = irwre_q;
  assign PC       = pc_q;
  assign PC4      = pc4_q;
  assign Halted   = halted_q;
  assign FetchErr = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised self-checking bench for instr_fetch_unit against a transaction-level PC model.
module tb_instr_fetch_unit;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] ExtImm;
  logic [31:0] ReadData1;
  logic [25:0] JumpAddr;
  logic [31:0] IAddr;
  logic        IReq;
  logic        IAck;
  logic [31:0] IRData;
  logic [31:0] IDataOut;
  logic        IRWre;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        Halted;
  logic        FetchErr;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_pc;

  instr_fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .ExtImm(ExtImm),
    .ReadData1(ReadData1), .JumpAddr(JumpAddr), .IAddr(IAddr), .IReq(IReq),
    .IAck(IAck), .IRData(IRData), .IDataOut(IDataOut), .IRWre(IRWre), .PC(PC),
    .PC4(PC4), .Halted(Halted), .FetchErr(FetchErr)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] src,
                                           input logic [31:0] ext, input logic [31:0] rd1,
                                           input logic [25:0] jaddr);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    case (src)
      2'd0:    return pc4;
      2'd1:    return pc4 + ext * 32'd4;
      2'd2:    return rd1 - (rd1 % 32'd4);
      default: return (pc4 - (pc4 % 32'h1000_0000)) + {6'd0, jaddr} * 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  task automatic do_fetch(input logic [31:0] data, input int delay);
    int n;
    n = 0;
    while (IReq !== 1'b1 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check_val("ireq_up", 32'(IReq), 32'd1);
    for (int i = 0; i < delay; i++) begin
      check_val("iaddr_wait", IAddr, model_pc);
      IAck   = 1'b0;
      IRData = $urandom;
      PCWre  = 1'($urandom_range(0, 1));
      PCSrc  = 2'($urandom_range(0, 3));
      @(negedge CLK);
      check_val("ireq_hold", 32'(IReq), 32'd1);
    end
    check_val("iaddr_ack", IAddr, model_pc);
    IAck   = 1'b1;
    IRData = data;
    PCWre  = 1'($urandom_range(0, 1));
    @(negedge CLK);
    IAck   = 1'b0;
    PCWre  = 1'b0;
    IRData = $urandom;
    check_val("irwre_on", 32'(IRWre), 32'd1);
    check_val("idata", IDataOut, data);
    check_val("ireq_drop", 32'(IReq), 32'd0);
    check_val("pc_in_fetch", PC, model_pc);
    @(negedge CLK);
    check_val("irwre_off", 32'(IRWre), 32'd0);
    check_val("halted", 32'(Halted), 32'(data[31:26] == 6'h3F));
  endtask

  task automatic do_exec(input logic [1:0] src, input logic [31:0] ext, input logic [31:0] rd1,
                         input logic [25:0] jaddr, input int idle);
    logic [31:0] exp_pc;
    for (int i = 0; i < idle; i++) begin
      PCWre = 1'b0;
      PCSrc = 2'($urandom_range(0, 3));
      @(negedge CLK);
      check_val("pc_exec_hold", PC, model_pc);
      check_val("ireq_exec", 32'(IReq), 32'd0);
    end
    PCWre     = 1'b1;
    PCSrc     = src;
    ExtImm    = ext;
    ReadData1 = rd1;
    JumpAddr  = jaddr;
    exp_pc    = ref_next(model_pc, src, ext, rd1, jaddr);
    @(negedge CLK);
    PCWre    = 1'b0;
    model_pc = exp_pc;
    check_val("pc_next", PC, exp_pc);
    check_val("pc4_next", PC4, exp_pc + 32'd4);
    check_val("iaddr_next", IAddr, exp_pc);
    check_val("ireq_start", 32'(IReq), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; PCWre = 1'b0; PCSrc = 2'd0; ExtImm = 32'd0; ReadData1 = 32'd0;
    JumpAddr = 26'd0; IAck = 1'b0; IRData = 32'd0;
    model_pc = 32'd0;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    // Reset values, first FETCH cycle has no request yet
    check_val("rst_pc", PC, 32'd0);
    check_val("rst_pc4", PC4, 32'd4);
    check_val("rst_iaddr", IAddr, 32'd0);
    check_val("rst_ireq", 32'(IReq), 32'd0);
    check_val("rst_idata", IDataOut, 32'd0);
    check_val("rst_irwre", 32'(IRWre), 32'd0);
    check_val("rst_halted", 32'(Halted), 32'd0);
    check_val("rst_ferr", 32'(FetchErr), 32'd0);

    // Test 1: ack after two wait cycles
    do_fetch(32'h0000_0020, 2);
    check_val("t1_pc4", PC4, 32'd4);

    // Tests 2 and 3: directed next-PC cases
    do_exec(2'b10, 32'd0, 32'h0000_0010, 26'd0, 1);
    do_fetch(rand_word(), 0);
    do_exec(2'b01, 32'hFFFF_FFFE, 32'd0, 26'd0, 0);
    check_val("t2_branch", PC, 32'h0000_000C);
    do_fetch(rand_word(), 1);
    do_exec(2'b11, 32'd0, 32'd0, 26'h000_0040, 2);
    check_val("t2_jump", PC, 32'h0000_0100);
    do_fetch(rand_word(), 0);
    do_exec(2'b10, 32'd0, 32'h0000_1237, 26'd0, 0);
    check_val("t3_jr", PC, 32'h0000_1234);
    PCWre = 1'b1;
    PCSrc = 2'b11;
    do_fetch(rand_word(), 3);
    check_val("t3_pcwre_ignored", PC, 32'h0000_1234);

    // Randomised instruction stream
    for (int k = 0; k < 40; k++) begin
      do_exec(2'($urandom_range(0, 3)), $urandom, $urandom, 26'($urandom),
              int'($urandom_range(0, 2)));
      do_fetch(rand_word(), int'($urandom_range(0, 3)));
    end

    // Test 4: halt opcode
    do_exec(2'($urandom_range(0, 3)), $urandom, $urandom, 26'($urandom), 0);
    do_fetch(32'hFC00_0000, 1);
    for (int i = 0; i < 20; i++) begin
      IAck  = 1'($urandom_range(0, 1));
      PCWre = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check_val("halt_ireq", 32'(IReq), 32'd0);
      check_val("halt_flag", 32'(Halted), 32'd1);
      check_val("halt_pc", PC, model_pc);
      check_val("halt_irwre", 32'(IRWre), 32'd0);
    end
    IAck = 1'b0; PCWre = 1'b0;

    // Test 5: reset asserted mid-request, late ack ignored
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    model_pc = 32'd0;
    @(negedge CLK);
    check_val("t5_ireq_before", 32'(IReq), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check_val("t5_ireq_async", 32'(IReq), 32'd0);
    check_val("t5_pc", PC, 32'd0);
    check_val("t5_pc4", PC4, 32'd4);
    check_val("t5_halted", 32'(Halted), 32'd0);
    check_val("t5_idata", IDataOut, 32'd0);
    IAck = 1'b1;
    IRData = 32'hDEAD_BEEF;
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    IAck = 1'b0;
    check_val("t5_no_capture", IDataOut, 32'd0);
    check_val("t5_no_irwre", 32'(IRWre), 32'd0);
    check_val("t5_ireq_again", 32'(IReq), 32'd1);
    do_fetch(rand_word(), 1);

`ifdef FETCH_TIMEOUT_EN
    // Test 6: ack in the last allowed cycle still delivers
    do_exec(2'b00, 32'd0, 32'd0, 26'd0, 0);
    for (int i = 0; i < 15; i++) begin
      check_val("t6_ferr_low", 32'(FetchErr), 32'd0);
      @(negedge CLK);
    end
    IAck = 1'b1;
    IRData = 32'h0000_0001;
    @(negedge CLK);
    IAck = 1'b0;
    check_val("t6_late_ack", 32'(IRWre), 32'd1);
    check_val("t6_no_err", 32'(FetchErr), 32'd0);
    @(negedge CLK);
    do_exec(2'b00, 32'd0, 32'd0, 26'd0, 0);
    for (int i = 0; i < 15; i++) begin
      check_val("t6_wait_ireq", 32'(IReq), 32'd1);
      @(negedge CLK);
    end
    @(negedge CLK);
    check_val("t6_ferr", 32'(FetchErr), 32'd1);
    check_val("t6_halted", 32'(Halted), 32'd1);
    check_val("t6_ireq", 32'(IReq), 32'd0);
`else
    check_val("ferr_tied", 32'(FetchErr), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
